// File: rtl/axi_lite_master_cmd.sv
// AXI4-Lite initiator: executes one single-beat read or write command at a time and
// returns the captured data/response on a local response port, counting non-OKAY responses.
module axi_lite_master_cmd #(
   parameter int ADDRESS      = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   // local command port
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDRESS-1:0]      cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [3:0]              cmd_wstrb,
   // local response port
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [ERRCNT_WIDTH-1:0] err_count,
   // write address channel
   output logic [ADDRESS-1:0]      M_AWADDR,
   output logic [2:0]              M_AWPROT,
   output logic                    M_AWVALID,
   input  logic                    M_AWREADY,
   // write data channel
   output logic [DATA_WIDTH-1:0]   M_WDATA,
   output logic [3:0]              M_WSTRB,
   output logic                    M_WVALID,
   input  logic                    M_WREADY,
   // write response channel
   input  logic [1:0]              M_BRESP,
   input  logic                    M_BVALID,
   output logic                    M_BREADY,
   // read address channel
   output logic [ADDRESS-1:0]      M_ARADDR,
   output logic [2:0]              M_ARPROT,
   output logic                    M_ARVALID,
   input  logic                    M_ARREADY,
   // read data channel
   input  logic [DATA_WIDTH-1:0]   M_RDATA,
   input  logic [1:0]              M_RRESP,
   input  logic                    M_RVALID,
   output logic                    M_RREADY
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_AW_W = 3'd1,
      ST_WR_B    = 3'd2,
      ST_RD_AR   = 3'd3,
      ST_RD_R    = 3'd4,
      ST_RSP     = 3'd5
   } state_t;

   state_t                  r_state;
   logic                    r_cmd_ready;
   logic [ADDRESS-1:0]      r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [3:0]              r_wstrb;
   logic                    r_awvalid;
   logic                    r_wvalid;
   logic                    r_aw_done;
   logic                    r_w_done;
   logic                    r_bready;
   logic                    r_arvalid;
   logic                    r_rready;
   logic                    r_rsp_valid;
   logic                    r_rsp_write;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic [1:0]              r_rsp_resp;
   logic [ERRCNT_WIDTH-1:0] r_err_count;

   logic       w_aw_done;
   logic       w_w_done;
   logic       w_b_fire;
   logic       w_r_fire;
   logic [1:0] w_cap_resp;

   // A channel counts as done either from an earlier handshake or from one on this edge.
   assign w_aw_done  = r_aw_done | (r_awvalid & M_AWREADY);
   assign w_w_done   = r_w_done  | (r_wvalid  & M_WREADY);
   assign w_b_fire   = (r_state == ST_WR_B) & M_BVALID & r_bready;
   assign w_r_fire   = (r_state == ST_RD_R) & M_RVALID & r_rready;
   assign w_cap_resp = w_b_fire ? M_BRESP : M_RRESP;

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= 2'b00;
         r_err_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= cmd_addr;
                  r_wdata     <= cmd_wdata;
                  r_wstrb     <= cmd_wstrb;
                  r_rsp_write <= cmd_write;
                  if (cmd_write) begin
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                     r_aw_done <= 1'b0;
                     r_w_done  <= 1'b0;
                     r_state   <= ST_WR_AW_W;
                  end else begin
                     r_arvalid <= 1'b1;
                     r_state   <= ST_RD_AR;
                  end
               end
            end
            ST_WR_AW_W: begin
               if (r_awvalid && M_AWREADY) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (r_wvalid && M_WREADY) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_done && w_w_done) begin
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
                  r_bready  <= 1'b1;
                  r_state   <= ST_WR_B;
               end
            end
            ST_WR_B: begin
               if (w_b_fire) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= M_BRESP;
                  r_rsp_rdata <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RSP;
               end
            end
            ST_RD_AR: begin
               if (r_arvalid && M_ARREADY) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
                  r_state   <= ST_RD_R;
               end
            end
            ST_RD_R: begin
               if (w_r_fire) begin
                  r_rready    <= 1'b0;
                  r_rsp_resp  <= M_RRESP;
                  r_rsp_rdata <= M_RDATA;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
            end
         endcase

         // Saturating count of non-OKAY responses, bumped on the capture edge.
         if ((w_b_fire || w_r_fire) && (w_cap_resp != 2'b00) && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERRCNT_WIDTH'(1);
         end
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_resp  = r_rsp_resp;
   assign err_count = r_err_count;

   assign M_AWADDR  = r_addr;
   assign M_AWPROT  = 3'b000;
   assign M_AWVALID = r_awvalid;
   assign M_WDATA   = r_wdata;
   assign M_WSTRB   = r_wstrb;
   assign M_WVALID  = r_wvalid;
   assign M_BREADY  = r_bready;
   assign M_ARADDR  = r_addr;
   assign M_ARPROT  = 3'b000;
   assign M_ARVALID = r_arvalid;
   assign M_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd: the bench plays the AXI slave by hand, driving
// inputs and sampling outputs on the falling edge, one directed step after another.
module tb_axi_lite_master_cmd;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [7:0]  err_count;
   logic [31:0] M_AWADDR;
   logic [2:0]  M_AWPROT;
   logic        M_AWVALID;
   logic        M_AWREADY;
   logic [31:0] M_WDATA;
   logic [3:0]  M_WSTRB;
   logic        M_WVALID;
   logic        M_WREADY;
   logic [1:0]  M_BRESP;
   logic        M_BVALID;
   logic        M_BREADY;
   logic [31:0] M_ARADDR;
   logic [2:0]  M_ARPROT;
   logic        M_ARVALID;
   logic        M_ARREADY;
   logic [31:0] M_RDATA;
   logic [1:0]  M_RRESP;
   logic        M_RVALID;
   logic        M_RREADY;

   int checks = 0;
   int errors = 0;

   always #5 ACLK = ~ACLK;

   axi_lite_master_cmd #(
      .ADDRESS      (32),
      .DATA_WIDTH   (32),
      .ERRCNT_WIDTH (8)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wstrb (cmd_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_write (rsp_write),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .err_count (err_count),
      .M_AWADDR  (M_AWADDR),
      .M_AWPROT  (M_AWPROT),
      .M_AWVALID (M_AWVALID),
      .M_AWREADY (M_AWREADY),
      .M_WDATA   (M_WDATA),
      .M_WSTRB   (M_WSTRB),
      .M_WVALID  (M_WVALID),
      .M_WREADY  (M_WREADY),
      .M_BRESP   (M_BRESP),
      .M_BVALID  (M_BVALID),
      .M_BREADY  (M_BREADY),
      .M_ARADDR  (M_ARADDR),
      .M_ARPROT  (M_ARPROT),
      .M_ARVALID (M_ARVALID),
      .M_ARREADY (M_ARREADY),
      .M_RDATA   (M_RDATA),
      .M_RRESP   (M_RRESP),
      .M_RVALID  (M_RVALID),
      .M_RREADY  (M_RREADY)
   );

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock: cross the rising edge, land on the next falling edge.
   task automatic tick();
      @(posedge ACLK);
      @(negedge ACLK);
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
   endtask

   initial begin
      ARESET    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_wstrb = '0;
      rsp_ready = 1'b0;
      M_AWREADY = 1'b0;
      M_WREADY  = 1'b0;
      M_BRESP   = 2'b00;
      M_BVALID  = 1'b0;
      M_ARREADY = 1'b0;
      M_RDATA   = '0;
      M_RRESP   = 2'b00;
      M_RVALID  = 1'b0;

      // ---- reset state ----
      @(negedge ACLK);
      tick();
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_outs", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 6'b0);
      check("rst_err", err_count, 8'h00);
      ARESET = 1'b0;
      tick();
      $display("reset: cmd_ready=%0b err_count=%0h", cmd_ready, err_count);

      // ---- write 0x0 <- 0xFF, zero-wait slave ----
      issue(1'b1, 32'h0, 32'h0000_00FF, 4'hF);
      tick();                                  // accept edge T passed -> cycle T+1
      cmd_valid = 1'b0;
      check("w1_valids_t1", {M_AWVALID, M_WVALID, cmd_ready}, 3'b110);
      check("w1_payload", {M_AWADDR, M_WDATA}, {32'h0, 32'h0000_00FF});
      check("w1_strb_prot", {M_WSTRB, M_AWPROT}, {4'hF, 3'b000});
      check("w1_bready_t1", M_BREADY, 1'b0);
      M_AWREADY = 1'b1;
      M_WREADY  = 1'b1;
      tick();                                  // cycle T+2
      M_AWREADY = 1'b0;
      M_WREADY  = 1'b0;
      check("w1_t2", {M_AWVALID, M_WVALID, M_BREADY, rsp_valid}, 4'b0010);
      M_BVALID = 1'b1;
      M_BRESP  = 2'b00;
      tick();                                  // cycle T+3
      M_BVALID = 1'b0;
      check("w1_rsp_valid_t3", {rsp_valid, rsp_write, M_BREADY}, 3'b110);
      check("w1_rsp_data", {rsp_rdata, rsp_resp}, {32'h0, 2'b00});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("w1_back_idle", {rsp_valid, cmd_ready}, 2'b01);
      $display("write 0x0<-0xFF: resp=%0h err=%0h", rsp_resp, err_count);

      // ---- write with AWREADY at T+1, WREADY at T+6 ----
      issue(1'b1, 32'h4, 32'hA5A5_1234, 4'h3);
      tick();                                  // T+1
      cmd_valid = 1'b0;
      M_AWREADY = 1'b1;
      check("w2_valids_t1", {M_AWVALID, M_WVALID}, 2'b11);
      for (int c = 2; c <= 5; c++) begin
         tick();                               // T+2 .. T+5
         M_AWREADY = 1'b0;
         check("w2_wait_valids", {M_AWVALID, M_WVALID, M_BREADY}, 3'b010);
         check("w2_wait_wdata", {M_WDATA, M_WSTRB}, {32'hA5A5_1234, 4'h3});
      end
      tick();                                  // T+6
      check("w2_t6_wvalid", {M_WVALID, M_BREADY}, 2'b10);
      M_WREADY = 1'b1;
      tick();                                  // T+7
      M_WREADY = 1'b0;
      check("w2_t7_bready", {M_WVALID, M_BREADY}, 2'b01);
      M_BVALID = 1'b1;
      M_BRESP  = 2'b00;
      tick();
      M_BVALID = 1'b0;
      check("w2_rsp", {rsp_valid, rsp_write, rsp_resp, err_count}, {1'b1, 1'b1, 2'b00, 8'h00});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      $display("write 0x4 delayed W: resp=%0h err=%0h", rsp_resp, err_count);

      // ---- read 0x8, RVALID 3 cycles after RREADY ----
      issue(1'b0, 32'h8, 32'h0, 4'h0);
      tick();                                  // T+1
      cmd_valid = 1'b0;
      check("r1_arvalid", {M_ARVALID, M_AWVALID, M_WVALID}, 3'b100);
      check("r1_araddr", {M_ARADDR, M_ARPROT}, {32'h8, 3'b000});
      M_ARREADY = 1'b1;
      tick();                                  // T+2
      M_ARREADY = 1'b0;
      check("r1_rready", {M_ARVALID, M_RREADY}, 2'b01);
      M_BVALID = 1'b1;                         // stray BVALID while reading
      for (int c = 0; c < 3; c++) begin
         tick();
         check("r1_wait", {M_RREADY, M_BREADY, rsp_valid}, 3'b100);
      end
      M_BVALID = 1'b0;
      M_RVALID = 1'b1;
      M_RDATA  = 32'h0000_0001;
      M_RRESP  = 2'b00;
      tick();
      M_RVALID = 1'b0;
      M_RDATA  = 32'h0;
      check("r1_rsp_flags", {rsp_valid, rsp_write, M_RREADY}, 3'b100);
      check("r1_rsp_data", {rsp_rdata, rsp_resp}, {32'h0000_0001, 2'b00});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      $display("read 0x8: rdata=%0h resp=%0h", rsp_rdata, rsp_resp);

      // ---- read 0x10 SLVERR, response held while rsp_ready low, pending command ----
      issue(1'b0, 32'h10, 32'h0, 4'h0);
      tick();
      cmd_valid = 1'b0;
      M_ARREADY = 1'b1;
      tick();
      M_ARREADY = 1'b0;
      M_RVALID  = 1'b1;
      M_RDATA   = 32'hDEAD_BEEF;
      M_RRESP   = 2'b10;
      tick();
      M_RVALID = 1'b0;
      M_RDATA  = 32'h0;
      M_RRESP  = 2'b00;
      check("r2_err_inc", err_count, 8'h01);
      issue(1'b1, 32'h20, 32'h1111_2222, 4'hF);
      for (int c = 0; c < 4; c++) begin
         check("r2_hold_rsp", {rsp_valid, rsp_rdata, rsp_resp}, {1'b1, 32'hDEAD_BEEF, 2'b10});
         check("r2_no_accept", {cmd_ready, M_AWVALID, M_WVALID}, 3'b000);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("r2_idle", {rsp_valid, cmd_ready, M_AWVALID}, 3'b010);
      $display("read 0x10: rdata=%0h resp=%0h err=%0h", rsp_rdata, rsp_resp, err_count);

      // ---- pending write accepted, reset while AWVALID high ----
      tick();
      cmd_valid = 1'b0;
      check("rs_awvalid_up", {M_AWVALID, M_WVALID}, 2'b11);
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      check("rs_dropped", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid}, 6'b0);
      check("rs_cmd_ready", {cmd_ready, err_count}, {1'b1, 8'h00});
      M_AWREADY = 1'b1;
      M_WREADY  = 1'b1;
      M_BVALID  = 1'b1;
      tick();
      check("rs_no_rsp", {rsp_valid, M_BREADY, M_AWVALID}, 3'b000);
      M_AWREADY = 1'b0;
      M_WREADY  = 1'b0;
      M_BVALID  = 1'b0;
      $display("reset mid-write: cmd_ready=%0b rsp_valid=%0b", cmd_ready, rsp_valid);

      // ---- 256 SLVERR reads: counter saturates at 0xFF ----
      for (int i = 0; i < 256; i++) begin
         issue(1'b0, 32'h30, 32'h0, 4'h0);
         tick();
         cmd_valid = 1'b0;
         M_ARREADY = 1'b1;
         tick();
         M_ARREADY = 1'b0;
         M_RVALID  = 1'b1;
         M_RRESP   = 2'b10;
         tick();
         M_RVALID = 1'b0;
         M_RRESP  = 2'b00;
         if (i == 0)   check("sat_first", err_count, 8'h01);
         if (i == 253) check("sat_254", err_count, 8'hFE);
         if (i == 254) check("sat_255", err_count, 8'hFF);
         if (i == 255) check("sat_256", err_count, 8'hFF);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
      $display("saturation: err_count=%0h after 256 SLVERR", err_count);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
